// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared types and constants for the ALU share arbiter
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int SEL_W_DEF = 2;
  localparam int CNT_W     = 16;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// rtl/alu_share_arbiter_rr.sv - combinational round-robin grant starting at ptr_i
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    int         j;
    logic       found;
    logic [IDX_W-1:0] jx;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    jx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      j = int'(ptr_i) + off;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jx = IDX_W'(j);
      if (en_i && !found && req_i[jx]) begin
        grant_o[jx] = 1'b1;
        idx_o       = jx;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU lane between NUM_REQ requesters
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_carry,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [SEL_W-1:0]          alu_sel,
  output logic                      alu_issue,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_carry,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LAT_W = 3;

  state_e               state_q;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gidx_q;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 rsp_carry_q;
  logic [DATA_W-1:0]    alu_a_q, alu_b_q;
  logic [SEL_W-1:0]     alu_sel_q;
  logic                 alu_issue_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     op_count_q;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     gidx;
  logic [DATA_W-1:0]    win_a, win_b;
  logic [SEL_W-1:0]     win_sel;

  // Grants are only offered in IDLE; reset suppresses them so the bus reads all-zero.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    ((state_q == IDLE) && !wb_rst_i),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IDX_W'(i)) begin
        win_a   = req_a[i*DATA_W +: DATA_W];
        win_b   = req_b[i*DATA_W +: DATA_W];
        win_sel = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  assign cnt_d = cnt_q - LAT_W'(1);
  assign ptr_d = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_issue_q <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      alu_issue_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|grant) begin
            alu_a_q     <= win_a;
            alu_b_q     <= win_b;
            alu_sel_q   <= win_sel;
            gidx_q      <= gidx;
            alu_issue_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= LAT_W'(ALU_LAT);
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            rsp_data_q  <= alu_out;
            rsp_carry_q <= alu_carry;
            rsp_valid_q <= NUM_REQ'(1) << gidx_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          // Only the granted requester's rsp_ready can complete the transfer.
          if (rsp_ready[gidx_q]) begin
            rsp_valid_q <= '0;
            op_count_q  <= sat_inc(op_count_q);
            ptr_q       <= ptr_d;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign alu_issue = alu_issue_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int L0 = 1;
  localparam int L1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int m_count = 0;

  // Instance 0 (ALU_LAT=1)
  logic [N-1:0]    req_valid0 = '0, req_ready0, rsp_valid0, rsp_ready0 = '1;
  logic [DW-1:0]   a0 [N];
  logic [DW-1:0]   b0 [N];
  logic [SW-1:0]   s0 [N];
  logic [N*DW-1:0] req_a0, req_b0;
  logic [N*SW-1:0] req_sel0;
  logic [DW-1:0]   rsp_data0, alu_a0, alu_b0, alu_out0;
  logic [SW-1:0]   alu_sel0;
  logic            rsp_carry0, alu_issue0, alu_carry0, busy0;
  logic [15:0]     op_count0;

  // Instance 1 (ALU_LAT=4)
  logic [N-1:0]    req_valid1 = '0, req_ready1, rsp_valid1, rsp_ready1 = '1;
  logic [DW-1:0]   a1 [N];
  logic [DW-1:0]   b1 [N];
  logic [SW-1:0]   s1 [N];
  logic [N*DW-1:0] req_a1, req_b1;
  logic [N*SW-1:0] req_sel1;
  logic [DW-1:0]   rsp_data1, alu_a1, alu_b1, alu_out1;
  logic [SW-1:0]   alu_sel1;
  logic            rsp_carry1, alu_issue1, alu_carry1, busy1;
  logic [15:0]     op_count1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a0[i*DW +: DW] = a0[i];
      req_b0[i*DW +: DW] = b0[i];
      req_sel0[i*SW +: SW] = s0[i];
      req_a1[i*DW +: DW] = a1[i];
      req_b1[i*DW +: DW] = b1[i];
      req_sel1[i*SW +: SW] = s1[i];
    end
  end

  alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .ALU_LAT(L0)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_a(req_a0), .req_b(req_b0), .req_sel(req_sel0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_data(rsp_data0), .rsp_carry(rsp_carry0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0), .alu_issue(alu_issue0),
    .alu_out(alu_out0), .alu_carry(alu_carry0),
    .busy(busy0), .op_count(op_count0)
  );

  alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .ALU_LAT(L1)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_sel(req_sel1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_data(rsp_data1), .rsp_carry(rsp_carry1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_issue(alu_issue1),
    .alu_out(alu_out1), .alu_carry(alu_carry1),
    .busy(busy1), .op_count(op_count1)
  );

  // Reference ALU: {carry, result}; carry is the borrow for SUB
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    case (s)
      ALU_ADD: return {1'b0, a} + {1'b0, b};
      ALU_SUB: return {1'b0, a} - {1'b0, b};
      ALU_AND: return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Bench ALUs: result valid exactly ALU_LAT cycles after issue, inverted garbage otherwise
  logic [7:0] hist0 = '0, hist1 = '0;
  logic [8:0] res0 = '0, res1 = '0;
  always @(posedge clk) begin
    hist0 <= {hist0[6:0], alu_issue0};
    hist1 <= {hist1[6:0], alu_issue1};
    if (alu_issue0) res0 <= alu_fn(alu_a0, alu_b0, alu_sel0);
    if (alu_issue1) res1 <= alu_fn(alu_a1, alu_b1, alu_sel1);
  end
  assign {alu_carry0, alu_out0} = hist0[L0-1] ? res0 : ~res0;
  assign {alu_carry1, alu_out1} = hist1[L1-1] ? res1 : ~res1;

  function automatic int exp_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input int i);
    logic [1:0] ix;
    ix = 2'(i);
    a0[ix] = 8'($urandom);
    b0[ix] = 8'($urandom);
    s0[ix] = 2'($urandom);
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_count = 0;
  endtask

  // One full transaction on instance 0 with optional response stall on stall_req
  task automatic serve_one(input int stall_req, input int stall_cyc, input bit drop,
                           output int w, output int t_acc);
    int budget;
    logic [1:0] wx;
    logic [7:0] ea, eb;
    logic [1:0] es;
    logic [8:0] ex;
    w = -1;
    t_acc = cyc;
    budget = 0;
    #1;
    while (req_ready0 == '0 && budget < 20) begin
      step();
      budget++;
    end
    n_tests++;
    if (req_ready0 == '0) begin
      n_fail++;
      $display("FAIL grant_timeout: req_ready=%b required a grant", req_ready0);
      return;
    end
    w  = exp_winner(req_valid0, m_ptr);
    wx = 2'(w);
    if (req_ready0 !== (N'(1) << w)) begin
      n_fail++;
      $display("FAIL grant: req_ready=%b required %b", req_ready0, N'(1) << w);
    end
    ea = a0[wx]; eb = b0[wx]; es = s0[wx];
    ex = alu_fn(ea, eb, es);
    t_acc = cyc;
    rsp_ready0 = (w == stall_req && stall_cyc > 0) ? ~(N'(1) << w) : '1;
    step();
    rand_ops(w);
    if (drop) req_valid0[wx] = 1'b0;
    n_tests++;
    if (alu_issue0 !== 1'b1 || alu_a0 !== ea || alu_b0 !== eb || alu_sel0 !== es || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL issue: issue=%b a=%h b=%h sel=%h busy=%b required 1 %h %h %h 1",
               alu_issue0, alu_a0, alu_b0, alu_sel0, busy0, ea, eb, es);
    end
    for (int k = 0; k < L0; k++) begin
      step();
      n_tests++;
      if (alu_issue0 !== 1'b0 || rsp_valid0 !== '0 || alu_a0 !== ea || alu_b0 !== eb || req_ready0 !== '0) begin
        n_fail++;
        $display("FAIL wait: issue=%b rsp_valid=%b a=%h b=%h req_ready=%b required 0 0 %h %h 0",
                 alu_issue0, rsp_valid0, alu_a0, alu_b0, req_ready0, ea, eb);
      end
    end
    step();
    n_tests++;
    if (rsp_valid0 !== (N'(1) << w) || rsp_data0 !== ex[7:0] || rsp_carry0 !== ex[8] || req_ready0 !== '0) begin
      n_fail++;
      $display("FAIL rsp: valid=%b data=%h carry=%b req_ready=%b required %b %h %b 0",
               rsp_valid0, rsp_data0, rsp_carry0, req_ready0, N'(1) << w, ex[7:0], ex[8]);
    end
    if (w == stall_req) begin
      for (int k = 0; k < stall_cyc - 1; k++) begin
        step();
        n_tests++;
        if (rsp_valid0 !== (N'(1) << w) || rsp_data0 !== ex[7:0] || rsp_carry0 !== ex[8] || req_ready0 !== '0) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h carry=%b req_ready=%b required %b %h %b 0",
                   rsp_valid0, rsp_data0, rsp_carry0, req_ready0, N'(1) << w, ex[7:0], ex[8]);
        end
      end
    end
    rsp_ready0 = '1;
    step();
    m_ptr = (w + 1) % N;
    if (m_count < 65535) m_count++;
    n_tests++;
    if (rsp_valid0 !== '0 || busy0 !== 1'b0 || op_count0 !== 16'(m_count)) begin
      n_fail++;
      $display("FAIL done: rsp_valid=%b busy=%b op_count=%0d required 0 0 %0d",
               rsp_valid0, busy0, op_count0, m_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid0 = '1;
    step();
    step();
    n_tests++;
    if (req_ready0 !== '0 || rsp_valid0 !== '0 || rsp_data0 !== '0 || rsp_carry0 !== 1'b0 ||
        alu_a0 !== '0 || alu_b0 !== '0 || alu_sel0 !== '0 || alu_issue0 !== 1'b0 ||
        busy0 !== 1'b0 || op_count0 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rv=%b data=%h c=%b a=%h b=%h sel=%h iss=%b busy=%b cnt=%0d required all 0",
               req_ready0, rsp_valid0, rsp_data0, rsp_carry0, alu_a0, alu_b0, alu_sel0, alu_issue0, busy0, op_count0);
    end
    req_valid0 = '0;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      n_tests++;
      if (req_ready0 !== '0 || busy0 !== 1'b0 || alu_issue0 !== 1'b0 || op_count0 !== '0) begin
        n_fail++;
        $display("FAIL idle: ready=%b busy=%b issue=%b op_count=%0d required 0 0 0 0",
                 req_ready0, busy0, alu_issue0, op_count0);
      end
    end
  endtask

  task automatic test_single_add();
    int w, t;
    a0[0] = 8'h0F; b0[0] = 8'h01; s0[0] = ALU_ADD;
    req_valid0 = 4'b0001;
    serve_one(-1, 0, 1'b1, w, t);
  endtask

  task automatic test_carry();
    int w, t;
    a0[0] = 8'hFF; b0[0] = 8'h02; s0[0] = ALU_ADD;
    req_valid0 = 4'b0001;
    serve_one(-1, 0, 1'b1, w, t);
    req_valid0 = '0;
  endtask

  task automatic test_round_robin();
    int w, t, t_prev;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) rand_ops(i);
    req_valid0 = '1;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      serve_one(-1, 0, 1'b0, w, t);
      n_tests++;
      if (w !== (i % N)) begin
        n_fail++;
        $display("FAIL rr_order: op %0d winner %0d required %0d", i, w, i % N);
      end
      if (i > 0) begin
        n_tests++;
        if (t - t_prev !== 3 + L0) begin
          n_fail++;
          $display("FAIL b2b_spacing: %0d cycles required %0d", t - t_prev, 3 + L0);
        end
      end
      t_prev = t;
    end
    req_valid0 = '0;
  endtask

  task automatic test_backpressure();
    int w, t;
    req_valid0 = '1;
    for (int i = 0; i < N; i++) serve_one(2, 5, 1'b0, w, t);
    req_valid0 = '0;
  endtask

  task automatic test_random();
    int w, t;
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < N; r++) rand_ops(r);
      req_valid0 = 4'($urandom_range(1, 15));
      serve_one(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)), 1'b1, w, t);
    end
    req_valid0 = '0;
  endtask

  task automatic test_reset_mid_wait();
    int budget;
    logic [8:0] ex;
    a1[1] = 8'h33; b1[1] = 8'h44; s1[1] = ALU_XOR;
    req_valid1 = 4'b0010;
    #1;
    budget = 0;
    while (req_ready1 == '0 && budget < 20) begin
      step();
      budget++;
    end
    step();
    req_valid1 = '0;
    step();
    step();
    n_tests++;
    if (busy1 !== 1'b1 || rsp_valid1 !== '0) begin
      n_fail++;
      $display("FAIL lat4_in_wait: busy=%b rsp_valid=%b required 1 0", busy1, rsp_valid1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++;
      if (rsp_valid1 !== '0 || busy1 !== 1'b0 || op_count1 !== '0 || alu_issue1 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort: rsp_valid=%b busy=%b op_count=%0d issue=%b required 0 0 0 0",
                 rsp_valid1, busy1, op_count1, alu_issue1);
      end
    end
    a1[1] = 8'hC8; b1[1] = 8'h4B; s1[1] = ALU_SUB;
    a1[3] = 8'h01; b1[3] = 8'h01; s1[3] = ALU_ADD;
    ex = alu_fn(8'hC8, 8'h4B, ALU_SUB);
    req_valid1 = 4'b1010;
    #1;
    n_tests++;
    if (req_ready1 !== 4'b0010) begin
      n_fail++;
      $display("FAIL after_reset_grant: req_ready=%b required 0010", req_ready1);
    end
    step();
    req_valid1 = '0;
    n_tests++;
    if (alu_issue1 !== 1'b1 || alu_a1 !== 8'hC8 || alu_b1 !== 8'h4B || alu_sel1 !== ALU_SUB) begin
      n_fail++;
      $display("FAIL lat4_issue: issue=%b a=%h b=%h sel=%h required 1 c8 4b 1",
               alu_issue1, alu_a1, alu_b1, alu_sel1);
    end
    for (int k = 0; k <= L1; k++) begin
      step();
      n_tests++;
      if (k < L1) begin
        if (rsp_valid1 !== '0 || alu_a1 !== 8'hC8) begin
          n_fail++;
          $display("FAIL lat4_wait: rsp_valid=%b a=%h required 0 c8", rsp_valid1, alu_a1);
        end
      end else if (rsp_valid1 !== 4'b0010 || rsp_data1 !== ex[7:0] || rsp_carry1 !== ex[8]) begin
        n_fail++;
        $display("FAIL lat4_rsp: valid=%b data=%h carry=%b required 0010 %h %b",
                 rsp_valid1, rsp_data1, rsp_carry1, ex[7:0], ex[8]);
      end
    end
    step();
    n_tests++;
    if (op_count1 !== 16'd1 || rsp_valid1 !== '0) begin
      n_fail++;
      $display("FAIL lat4_done: op_count=%0d rsp_valid=%b required 1 0", op_count1, rsp_valid1);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a0[i] = '0; b0[i] = '0; s0[i] = '0;
      a1[i] = '0; b1[i] = '0; s1[i] = '0;
    end
    test_reset();
    test_single_add();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
